// File: rtl/vote_button_conditioner.sv
// Conditions four raw candidate buttons into single-cycle vote pulses:
// 2-FF sync, per-button debounce, press/release/lockout FSM, display-mode select.
module vote_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       candid1,
  input  logic       candid2,
  input  logic       candid3,
  input  logic       candid4,
  output logic [3:0] vote,
  output logic [3:0] sel,
  output logic       conflict,
  output logic       busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LD  = LW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    LOCKOUT      = 2'd2
  } state_t;

  logic [3:0]    raw_s;
  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic [3:0]    db_r;
  logic [DW-1:0] db_cnt_r [4];
  logic [LW-1:0] lock_cnt_r;
  logic          multi_s;
  state_t        state_r;

  assign raw_s   = {candid4, candid3, candid2, candid1};
  // More than one debounced button high: clearing the lowest set bit leaves something.
  assign multi_s = |(db_r & (db_r - 4'd1));

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 4'd0;
      sync2_r <= 4'd0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: db toggles once the synced level has disagreed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_r <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_cnt_r[i] <= '0;
          db_r[i]     <= sync2_r[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  // Press/release/lockout FSM with registered vote, conflict, sel and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      lock_cnt_r <= '0;
      vote       <= 4'd0;
      sel        <= 4'd0;
      conflict   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vote     <= 4'd0;
      conflict <= 1'b0;
      sel      <= db_r & {4{mode}};
      case (state_r)
        IDLE: begin
          if (db_r != 4'd0) begin
            state_r <= WAIT_RELEASE;
            busy    <= 1'b1;
            if (multi_s) begin
              conflict <= 1'b1;
            end else if (!mode) begin
              vote <= db_r;
            end else begin
              vote <= 4'd0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        WAIT_RELEASE: begin
          busy <= 1'b1;
          if (db_r == 4'd0) begin
            state_r    <= LOCKOUT;
            lock_cnt_r <= LOCK_LD;
          end else begin
            state_r <= WAIT_RELEASE;
          end
        end
        LOCKOUT: begin
          // A press still debounced when the count expires is treated as held, not new.
          if (lock_cnt_r <= LW'(1)) begin
            lock_cnt_r <= '0;
            if (db_r == 4'd0) begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_r <= WAIT_RELEASE;
              busy    <= 1'b1;
            end
          end else begin
            lock_cnt_r <= lock_cnt_r - LW'(1);
            busy       <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          lock_cnt_r <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_button_conditioner.sv
// Self-checking bench: directed scenarios plus random presses, compared against a
// history-based reference model of debounce, press acceptance and lockout timing.
module tb_vote_button_conditioner;

  localparam int DEB  = 8;
  localparam int LOCK = 8;
  localparam int HMAX = 16384;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       candid1, candid2, candid3, candid4;
  logic [3:0] vote, sel;
  logic       conflict, busy;

  int errors = 0;
  int checks = 0;

  vote_button_conditioner #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .candid1(candid1), .candid2(candid2), .candid3(candid3), .candid4(candid4),
    .vote(vote), .sel(sel), .conflict(conflict), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: raw history per edge, debounced level per edge, coarse phase.
  int         t;
  logic [3:0] rawh [0:HMAX-1];
  logic [3:0] dbh  [0:HMAX-1];
  int         phase;      // 0 ready, 1 held, 2 cooling
  int         cool_end;
  logic [3:0] exp_vote, exp_sel;
  logic       exp_conf, exp_busy;

  task automatic model_reset();
    t = 0;
    for (int k = 0; k < HMAX; k++) begin
      rawh[k] = 4'd0;
      dbh[k]  = 4'd0;
    end
    phase    = 0;
    cool_end = 0;
    exp_vote = 4'd0;
    exp_sel  = 4'd0;
    exp_conf = 1'b0;
    exp_busy = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] b, input logic m);
    logic [3:0] d;
    logic       prev, flip, smp;
    int         idx;
    if (t < HMAX - 2) t++;
    rawh[t] = b;
    // A level reaches the debouncer two edges after it is sampled.
    for (int i = 0; i < 4; i++) begin
      prev = dbh[t-1][i];
      flip = (t >= DEB);
      for (int j = 0; j < DEB; j++) begin
        idx = t - j - 2;
        smp = (idx >= 1) ? rawh[idx][i] : 1'b0;
        if (smp == prev) flip = 1'b0;
      end
      dbh[t][i] = flip ? ~prev : prev;
    end
    d        = dbh[t-1];
    exp_sel  = d & {4{m}};
    exp_vote = 4'd0;
    exp_conf = 1'b0;
    if (phase == 0) begin
      if (d != 4'd0) begin
        if ($countones(d) > 1) exp_conf = 1'b1;
        else if (!m) exp_vote = d;
        phase = 1;
      end
    end else if (phase == 1) begin
      if (d == 4'd0) begin
        phase    = 2;
        cool_end = t + LOCK;
      end
    end else begin
      if (t == cool_end) phase = (d == 4'd0) ? 0 : 1;
    end
    exp_busy = (phase != 0);
  endtask

  task automatic tick(input logic [3:0] b, input logic m);
    {candid4, candid3, candid2, candid1} = b;
    mode = m;
    @(posedge clk);
    model_edge(b, m);
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    for (int c = 0; c < n; c++) tick(4'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = 1'b0;
    {candid4, candid3, candid2, candid1} = 4'd0;
    repeat (10) @(negedge clk);
    checks++;
    if ({vote, conflict, busy, sel} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got vote=%b conf=%b busy=%b sel=%b want all zero", vote, conflict, busy, sel);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_clean_press();
    int nv, at;
    nv = 0; at = -1;
    for (int c = 0; c < 45; c++) begin
      tick((c < 15) ? 4'b0001 : 4'b0000, 1'b0);
      checks++;
      if ({vote, conflict, busy, sel} !== {exp_vote, exp_conf, exp_busy, exp_sel}) begin
        errors++;
        $display("FAIL clean_press c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, vote, conflict, busy, sel, exp_vote, exp_conf, exp_busy, exp_sel);
      end
      if (vote != 4'd0) begin nv++; at = c + 1; end
    end
    checks++;
    if (nv != 1 || at != DEB + 3) begin
      errors++;
      $display("FAIL clean_press_latency got pulses=%0d at=%0d want 1 at %0d", nv, at, DEB + 3);
    end
  endtask

  task automatic test_repeat();
    int n1, n2, nc;
    logic [3:0] b;
    n1 = 0; n2 = 0; nc = 0;
    settle(30);
    for (int p = 0; p < 9; p++) begin
      b = (p < 5) ? 4'b0001 : 4'b0010;
      for (int c = 0; c < 25; c++) begin
        tick((c < 15) ? b : 4'b0000, 1'b0);
        checks++;
        if ({vote, conflict, busy, sel} !== {exp_vote, exp_conf, exp_busy, exp_sel}) begin
          errors++;
          $display("FAIL repeat p=%0d c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", p, c, vote, conflict, busy, sel, exp_vote, exp_conf, exp_busy, exp_sel);
        end
        if (vote == 4'b0001) n1++;
        if (vote == 4'b0010) n2++;
        if (conflict) nc++;
      end
    end
    checks++;
    if (n1 != 5 || n2 != 4 || nc != 0) begin
      errors++;
      $display("FAIL repeat_counts got c1=%0d c2=%0d conf=%0d want 5 4 0", n1, n2, nc);
    end
  endtask

  task automatic test_glitch_hold();
    int nv, nb, n4;
    nv = 0; nb = 0; n4 = 0;
    settle(30);
    for (int c = 0; c < 30; c++) begin
      tick((c < 5) ? 4'b0100 : 4'b0000, 1'b0);
      checks++;
      if ({vote, conflict, busy, sel} !== {exp_vote, exp_conf, exp_busy, exp_sel}) begin
        errors++;
        $display("FAIL glitch c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, vote, conflict, busy, sel, exp_vote, exp_conf, exp_busy, exp_sel);
      end
      if (vote != 4'd0) nv++;
      if (busy) nb++;
    end
    checks++;
    if (nv != 0 || nb != 0) begin
      errors++;
      $display("FAIL glitch_reject got votes=%0d busy_cycles=%0d want 0 0", nv, nb);
    end
    for (int c = 0; c < 230; c++) begin
      tick((c < 200) ? 4'b1000 : 4'b0000, 1'b0);
      checks++;
      if ({vote, conflict, busy, sel} !== {exp_vote, exp_conf, exp_busy, exp_sel}) begin
        errors++;
        $display("FAIL hold c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, vote, conflict, busy, sel, exp_vote, exp_conf, exp_busy, exp_sel);
      end
      if (vote == 4'b1000) n4++;
    end
    checks++;
    if (n4 != 1) begin
      errors++;
      $display("FAIL hold_single_vote got %0d want 1", n4);
    end
  endtask

  task automatic test_simultaneous();
    int nv, nc;
    nv = 0; nc = 0;
    settle(30);
    for (int c = 0; c < 45; c++) begin
      tick((c < 15) ? 4'b0011 : 4'b0000, 1'b0);
      checks++;
      if ({vote, conflict, busy, sel} !== {exp_vote, exp_conf, exp_busy, exp_sel}) begin
        errors++;
        $display("FAIL simul c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, vote, conflict, busy, sel, exp_vote, exp_conf, exp_busy, exp_sel);
      end
      if (vote != 4'd0) nv++;
      if (conflict) nc++;
    end
    checks++;
    if (nv != 0 || nc != 1) begin
      errors++;
      $display("FAIL simul_conflict got votes=%0d conflicts=%0d want 0 1", nv, nc);
    end
  endtask

  task automatic test_lockout();
    int nv, ndrop;
    logic [3:0] b;
    nv = 0; ndrop = 0;
    settle(30);
    // Short raw release: the re-press debounces while the lockout is still counting.
    for (int c = 0; c < 83; c++) begin
      b = (c < 15 || (c >= 23 && c < 43)) ? 4'b0010 : 4'b0000;
      tick(b, 1'b0);
      checks++;
      if ({vote, conflict, busy, sel} !== {exp_vote, exp_conf, exp_busy, exp_sel}) begin
        errors++;
        $display("FAIL lockout c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, vote, conflict, busy, sel, exp_vote, exp_conf, exp_busy, exp_sel);
      end
      if (vote != 4'd0) nv++;
      if (c >= 11 && c < 43 && !busy) ndrop++;
    end
    checks++;
    if (nv != 1 || ndrop != 0) begin
      errors++;
      $display("FAIL lockout_reject got votes=%0d busy_drops=%0d want 1 0", nv, ndrop);
    end
  endtask

  task automatic test_display_reset();
    int nv, nsel;
    nv = 0; nsel = 0;
    settle(30);
    for (int c = 0; c < 40; c++) begin
      tick((c < 15) ? 4'b0100 : 4'b0000, 1'b1);
      checks++;
      if ({vote, conflict, busy, sel} !== {exp_vote, exp_conf, exp_busy, exp_sel}) begin
        errors++;
        $display("FAIL display c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, vote, conflict, busy, sel, exp_vote, exp_conf, exp_busy, exp_sel);
      end
      if (vote != 4'd0) nv++;
      if (sel == 4'b0100) nsel++;
    end
    checks++;
    if (nv != 0 || nsel == 0 || sel !== 4'd0) begin
      errors++;
      $display("FAIL display_sel got votes=%0d sel_cycles=%0d final_sel=%b want 0 >0 0000", nv, nsel, sel);
    end
    for (int c = 0; c < 15; c++) tick(4'b0100, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if ({vote, conflict, busy, sel} !== 10'd0) begin
      errors++;
      $display("FAIL reset_midpress got vote=%b conf=%b busy=%b sel=%b want all zero", vote, conflict, busy, sel);
    end
    mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    nv = 0;
    for (int c = 0; c < 60; c++) begin
      tick((c < 30) ? 4'b0100 : 4'b0000, 1'b0);
      checks++;
      if ({vote, conflict, busy, sel} !== {exp_vote, exp_conf, exp_busy, exp_sel}) begin
        errors++;
        $display("FAIL post_reset c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, vote, conflict, busy, sel, exp_vote, exp_conf, exp_busy, exp_sel);
      end
      if (vote == 4'b0100) nv++;
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL post_reset_vote got %0d want 1", nv);
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic       m;
    int         hi, lo, r;
    settle(30);
    for (int e = 0; e < 40; e++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       b = 4'b0001 << $urandom_range(0, 3);
      else if (r < 8)  b = 4'($urandom_range(1, 15));
      else             b = 4'd0;
      m  = ($urandom_range(0, 3) == 0);
      hi = $urandom_range(1, 30);
      lo = $urandom_range(1, 30);
      for (int c = 0; c < hi + lo; c++) begin
        tick((c < hi) ? b : 4'b0000, m);
        checks++;
        if ({vote, conflict, busy, sel} !== {exp_vote, exp_conf, exp_busy, exp_sel}) begin
          errors++;
          $display("FAIL random e=%0d c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", e, c, vote, conflict, busy, sel, exp_vote, exp_conf, exp_busy, exp_sel);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mode = 1'b0;
    {candid4, candid3, candid2, candid1} = 4'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_repeat();
    test_glitch_hold();
    test_simultaneous();
    test_lockout();
    test_display_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
